// File: rtl/pll_mon_pkg.sv
// -----------------------------------------------------------------------------
// pll_mon_pkg
//
// Purpose:
//   Shared definitions for the PLL lock monitor: the supervisor state
//   encoding, the default cycle constants used as parameter defaults, and a
//   small helper used to size the internal counters.
//
// Contents:
//   pll_mon_state_e        supervisor FSM state (PLL_RST, WAIT_LOCK, RUN)
//   DEF_RST_PULSE_CYCLES   default refclk cycles of PLL reset per attempt
//   DEF_LOCK_STABLE_CYCLES default consecutive locked cycles before release
//   DEF_LOCK_TIMEOUT_CYCLES default WAIT_LOCK budget before a retry
//   DEF_CNT_W              default width of the event counters
//   max_u()                larger of two unsigned values
// -----------------------------------------------------------------------------
package pll_mon_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2
    } pll_mon_state_e;

    localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_CNT_W               = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : pll_mon_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Purpose:
//   Single-bit two-flop synchroniser for a level signal that is asynchronous
//   to clk_i. Both flops clear asynchronously on rst_i, so the synchronised
//   output reads 0 while the destination domain is in reset.
//
// Ports:
//   clk_i  in   destination clock
//   rst_i  in   asynchronous active-high reset
//   d_i    in   asynchronous input level
//   q_o    out  synchronised level, two clk_i edges behind d_i
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/pll_lock_monitor.sv
// -----------------------------------------------------------------------------
// pll_lock_monitor
//
// Purpose:
//   Supervises a PLL from the reference-clock side. The PLL is held in reset
//   for RST_PULSE_CYCLES, then the monitor waits for the synchronised lock
//   indication to stay high for LOCK_STABLE_CYCLES consecutive cycles before
//   releasing the downstream reset. If lock does not settle within
//   LOCK_TIMEOUT_CYCLES, or lock drops while running, the PLL is reset again
//   and the event is counted in a saturating counter.
//
// Parameters:
//   RST_PULSE_CYCLES     cycles pll_rst is held per attempt (>= 1)
//   LOCK_STABLE_CYCLES   consecutive locked cycles needed for release (>= 1)
//   LOCK_TIMEOUT_CYCLES  WAIT_LOCK budget; must exceed LOCK_STABLE_CYCLES
//   CNT_W                width of the event counters
//
// Ports:
//   refclk         in   reference clock (single clock domain)
//   rst            in   asynchronous active-high reset
//   pll_locked     in   PLL lock indication, asynchronous to refclk
//   clear_stats    in   synchronous pulse, zeroes both event counters
//   pll_rst        out  PLL reset, high in PLL_RST
//   sys_rst        out  downstream synchronous reset, low only in RUN
//   ready          out  high only in RUN
//   lock_loss_cnt  out  saturating count of RUN -> PLL_RST transitions
//   timeout_cnt    out  saturating count of WAIT_LOCK timeouts
//   state_dbg      out  current supervisor state, for observation only
//
// All outputs are Moore outputs registered alongside the state, so they
// change on the same edge as the state and have no combinational path from
// any input.
// -----------------------------------------------------------------------------
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W               = DEF_CNT_W
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 clear_stats,
    output logic                 pll_rst,
    output logic                 sys_rst,
    output logic                 ready,
    output logic [CNT_W-1:0]     lock_loss_cnt,
    output logic [CNT_W-1:0]     timeout_cnt,
    output pll_mon_state_e       state_dbg
);

    // One cycle counter serves both the PLL reset pulse and the WAIT_LOCK
    // timeout, since the two are never active at the same time.
    localparam int unsigned CYC_MAX = max_u(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
    localparam int unsigned STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);

    // Terminal values: a transition fires on the edge at which the count
    // including the current cycle reaches the parameter.
    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);

    // ---------------------------------------------------------------------
    // Lock synchroniser
    // ---------------------------------------------------------------------
    logic locked_s;

    sync_2ff u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    // ---------------------------------------------------------------------
    // State, counters and registered outputs
    // ---------------------------------------------------------------------
    pll_mon_state_e   state_q,   state_d;
    logic [CYC_W-1:0] cyc_q,     cyc_d;
    logic [STB_W-1:0] stb_q,     stb_d;
    logic [CNT_W-1:0] loss_q,    loss_d;
    logic [CNT_W-1:0] tmo_q,     tmo_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q,   ready_d;

    logic             loss_evt;
    logic             tmo_evt;

    // Next-state logic. Every transition clears both the cycle counter and
    // the stable counter so each state starts counting from zero.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        loss_evt = 1'b0;
        tmo_evt  = 1'b0;

        unique case (state_q)
            ST_PLL_RST: begin
                if (cyc_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cyc_d   = '0;
                    stb_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                // Stable release is checked first so that it wins when it
                // coincides with the timeout.
                if (locked_s && (stb_q == STB_LAST)) begin
                    state_d = ST_RUN;
                    cyc_d   = '0;
                    stb_d   = '0;
                end else if (cyc_q == TMO_LAST) begin
                    state_d = ST_PLL_RST;
                    tmo_evt = 1'b1;
                    cyc_d   = '0;
                    stb_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                    stb_d = locked_s ? (stb_q + 1'b1) : '0;
                end
            end

            ST_RUN: begin
                // Loss is acted on immediately: one low synchronised sample
                // is enough to re-reset the PLL.
                if (!locked_s) begin
                    state_d  = ST_PLL_RST;
                    loss_evt = 1'b1;
                    cyc_d    = '0;
                    stb_d    = '0;
                end
            end

            default: begin
                state_d = ST_PLL_RST;
                cyc_d   = '0;
                stb_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the next state so the registered copies
    // line up with the registered state.
    always_comb begin
        pll_rst_d = (state_d == ST_PLL_RST);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
    end

    // Saturating event counters. A coincident clear takes priority and the
    // event in that cycle is dropped.
    always_comb begin
        loss_d = loss_q;
        tmo_d  = tmo_q;
        if (clear_stats) begin
            loss_d = '0;
            tmo_d  = '0;
        end else begin
            if (loss_evt && (loss_q != '1)) begin
                loss_d = loss_q + 1'b1;
            end
            if (tmo_evt && (tmo_q != '1)) begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            cyc_q     <= '0;
            stb_q     <= '0;
            loss_q    <= '0;
            tmo_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            loss_q    <= loss_d;
            tmo_q     <= tmo_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;
    assign timeout_cnt   = tmo_q;
    assign state_dbg     = state_q;

endmodule : pll_lock_monitor
